fifo_word_drain: RTL
====================

Name: fifo_word_drain

Overview:
- Consumer stage directly downstream of fifo_flush_qs.
- Pulls 32-bit words from the FIFO read port whenever a full word is available.
- Buffers the words in a 2-entry output queue and presents them to a valid/ready sink.
- Requests a FIFO flush when partial data has sat unread for TIMEOUT cycles, or on an explicit request, so trailing nibbles are not stranded.

Parameters:
- DATA_W, 32, word width; matches the FIFO read data width.
- TIMEOUT, 8, consecutive cycles of "partial data, no full word" before an automatic flush (>=2).
- TMR_W, 4, width of the timeout counter; must hold TIMEOUT-1.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_data_avail_i  input  1  FIFO holds at least one complete word.
- fifo_empty_i  input  1  FIFO holds no data at all.
- fifo_flush_done_i  input  1  FIFO has completed the requested flush.
- fifo_rd_data_i  input  DATA_W  FIFO read data; valid the cycle after a read pulse.
- fifo_rd_valid_o  output  1  single-cycle read request to the FIFO (its fifo_rd_valid_i).
- fifo_flush_o  output  1  flush request to the FIFO (its fifo_flush_i).
- flush_req_i  input  1  explicit flush request; sampled only in IDLE.
- out_valid_o  output  1  out_data_o holds a word.
- out_ready_i  input  1  sink accepts the word.
- out_data_o  output  DATA_W  head word of the output queue.
- words_out_o  output  CNT_W  count of words delivered to the sink; wraps at 2^CNT_W.

Behaviour:
- Reset:
  - Synchronous, active-high; the clock is clk.
  - fifo_rd_valid_o=0, fifo_flush_o=0, out_valid_o=0, out_data_o=0, words_out_o=0.
  - Queue empty, timer=0, in-flight flag=0, state=IDLE.
  - Reset mid-operation discards any in-flight read and any queued words, and drops fifo_flush_o the next cycle.
- States:
  - IDLE: normal draining.
  - FLUSH: fifo_flush_o held at 1.
- Read issue:
  - fifo_rd_valid_o=1 for exactly one cycle when all of the following hold: state=IDLE, fifo_data_avail_i=1, no read in flight, and (queue occupancy + in-flight) < 2.
  - At most one outstanding read, so the maximum rate is one read per 2 cycles.
- Capture:
  - The cycle after a read pulse, fifo_rd_data_i is written to the queue tail and the in-flight flag clears.
  - Read-to-out_valid_o latency is 2 clk edges from the pulse when the queue was empty.
- Output queue:
  - 2-entry FIFO.
  - out_valid_o = occupancy != 0; out_data_o = head entry. out_data_o keeps its last value when the queue is empty.
  - Pop on out_valid_o && out_ready_i; words_out_o increments on each pop and wraps to 0.
  - Simultaneous capture and pop: occupancy unchanged, order preserved.
  - The queue never overflows, guaranteed by the credit rule above.
- Timeout timer:
  - In IDLE, increments while fifo_empty_i=0 && fifo_data_avail_i=0.
  - Otherwise clears to 0.
  - When timer==TIMEOUT-1 and the condition still holds, go to FLUSH next cycle and clear the timer.
- Explicit flush: in IDLE, flush_req_i=1 moves to FLUSH next cycle. It is ignored while in FLUSH.
- FLUSH state:
  - fifo_flush_o=1; no new reads issued. An in-flight read still completes.
  - On fifo_flush_done_i=1: deassert fifo_flush_o next cycle and return to IDLE.
  - Entering FLUSH with fifo_empty_i=1 is legal; it waits for fifo_flush_done_i.
- Precedence:
  - reset > flush_done exit > timeout/flush_req entry > read issue.
  - A read pulse is never issued in the same cycle the state enters FLUSH.

Test Plan:
- Reset, then fifo_data_avail_i=1 with data 0x0000068A and out_ready_i=1. Required: fifo_rd_valid_o pulses at cycle 1; out_valid_o=1 with out_data_o=0x0000068A at cycle 2; words_out_o=1 at cycle 3.
- out_ready_i=0 while fifo_data_avail_i stays 1. Required: exactly 2 read pulses, then none. Raise out_ready_i: words pop in order and reads resume; no word is lost or duplicated.
- fifo_empty_i=0 and fifo_data_avail_i=0 held for 8 cycles (TIMEOUT=8). Required: fifo_flush_o=1 from cycle 9. Return fifo_flush_done_i=1 at cycle 12: fifo_flush_o=0 at cycle 13. The resulting fifo_data_avail_i=1 triggers a read.
- Partial condition held for 5 cycles, then fifo_data_avail_i=1 for 1 cycle. Required: the timer clears, no flush occurs, and a read is issued.
- flush_req_i pulse in IDLE while a read is in flight. Required: the in-flight word is captured, fifo_flush_o asserts, and no further reads occur until fifo_flush_done_i.
- Assert reset during FLUSH with 2 words queued. Required: all outputs 0 next cycle, words_out_o=0, and the queue is empty.

Source files
------------

// File: rtl/fifo_word_drain.sv
// fifo_word_drain: drains complete words from fifo_flush_qs into a 2-entry
// output queue for a valid/ready sink, and asks the FIFO to flush when
// partial data sits unread for TIMEOUT cycles or on an explicit request.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   fifo_data_avail_i     FIFO holds at least one full word
//   fifo_empty_i          FIFO holds no data at all
//   fifo_flush_done_i     FIFO finished the requested flush
//   fifo_rd_data_i        FIFO read data, captured the edge after a read pulse
//   fifo_rd_valid_o       one-cycle read request
//   fifo_flush_o          flush request, high for the whole FLUSH state
//   flush_req_i           explicit flush request, honoured only in IDLE
//   out_valid_o           out_data_o holds a queued word
//   out_ready_i           sink accepts the head word
//   out_data_o            head of the output queue, held when empty
//   words_out_o           wrapping count of words delivered to the sink
module fifo_word_drain #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 8,
    parameter int TMR_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_data_avail_i,
    input  logic              fifo_empty_i,
    input  logic              fifo_flush_done_i,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    output logic              fifo_rd_valid_o,
    output logic              fifo_flush_o,
    input  logic              flush_req_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  words_out_o
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [1:0]        occ;
    logic [DATA_W-1:0] tail;

    logic              pop;
    logic              partial;
    logic              timed_out;
    logic              can_read;
    logic [1:0]        occ_n;
    logic [DATA_W-1:0] head_n;
    logic [DATA_W-1:0] tail_n;

    // Read data is captured on the edge right after the pulse, so the
    // registered pulse itself serves as the in-flight flag.
    assign pop       = out_valid_o && out_ready_i;
    assign partial   = !fifo_empty_i && !fifo_data_avail_i;
    assign timed_out = partial && (timer == TMR_W'(TIMEOUT - 1));
    assign can_read  = fifo_data_avail_i && !fifo_rd_valid_o
                       && (occ < 2'd2);

    // Output queue: out_data_o is the head slot, tail is the second slot.
    always_comb begin
        occ_n  = occ;
        head_n = out_data_o;
        tail_n = tail;
        unique case ({fifo_rd_valid_o, pop})
            2'b10: begin
                if (occ == 2'd0) begin
                    head_n = fifo_rd_data_i;
                end else begin
                    tail_n = fifo_rd_data_i;
                end
                occ_n = occ + 2'd1;
            end
            2'b01: begin
                // a lone last word is popped without touching the head
                if (occ == 2'd2) begin
                    head_n = tail;
                end
                occ_n = occ - 2'd1;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    head_n = fifo_rd_data_i;
                end else begin
                    head_n = tail;
                    tail_n = fifo_rd_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            occ             <= '0;
            tail            <= '0;
            fifo_rd_valid_o <= 1'b0;
            fifo_flush_o    <= 1'b0;
            out_valid_o     <= 1'b0;
            out_data_o      <= '0;
            words_out_o     <= '0;
        end else begin
            occ             <= occ_n;
            out_valid_o     <= (occ_n != 2'd0);
            out_data_o      <= head_n;
            tail            <= tail_n;
            fifo_rd_valid_o <= 1'b0;
            if (pop) begin
                words_out_o <= words_out_o + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (timed_out || flush_req_i) begin
                        state        <= FLUSH;
                        fifo_flush_o <= 1'b1;
                        timer        <= '0;
                    end else begin
                        timer <= partial ? timer + TMR_W'(1) : '0;
                        if (can_read) begin
                            fifo_rd_valid_o <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    timer <= '0;
                    if (fifo_flush_done_i) begin
                        state        <= IDLE;
                        fifo_flush_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
